// File: rtl/button_encoder_pkg.sv
// button_encoder_pkg: types and constants shared by the button/key input path.
//   state_e   - press-tracking FSM state
//   CODE_W    - width of the encoded line index
//   N_LINES   - number of button/key lines
//   lowest_index / multi_hot - helpers for building an event from a line vector
package button_encoder_pkg;

  localparam int unsigned CODE_W  = 3;
  localparam int unsigned N_LINES = 8;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_e;

  // Index of the lowest active line; 0 when no line is active.
  function automatic logic [CODE_W-1:0] lowest_index(input logic [N_LINES-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int unsigned i = N_LINES; i > 0; i--) begin
      if (v[i-1]) idx = CODE_W'(i - 1);
    end
    return idx;
  endfunction

  // True when more than one line is active (clearing the lowest set bit leaves something).
  function automatic logic multi_hot(input logic [N_LINES-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/button_encoder_debounce_vec.sv
// debounce_vec: two-flop synchroniser plus whole-vector debounce.
//   clk_i          - system clock
//   rst_i          - synchronous active-high reset
//   raw_n_i        - raw active-low lines, asynchronous to clk_i
//   stable_o       - debounced vector, active-high (1 = pressed)
//   stable_next_o  - value stable_o takes on the next edge, so the consumer can
//                    register its own reaction on the same edge as stable_o
// The candidate and stable vectors are kept active-low so that reset ('1)
// means "all released"; inversion happens only on the outputs.
module debounce_vec #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] raw_n_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] stable_next_o
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stab_q, stab_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    stab_d = stab_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) stab_d = cand_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
      cand_q  <= '1;
      stab_q  <= '1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_n_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stable_o      = ~stab_q;
  // Reset has priority, so the next value is "released" while rst_i is high.
  assign stable_next_o = rst_i ? '0 : ~stab_d;

endmodule

// File: rtl/button_encoder.sv
// button_encoder: 8 active-low button lines -> one 3-bit code per press,
// delivered over a one-deep valid/ready handshake.
//   clk      - system clock
//   rst      - synchronous active-high reset
//   btn_n    - raw active-low lines (0 = pressed), asynchronous
//   code     - lowest pressed line of the pending event, stable while valid
//   valid    - event pending
//   ready    - consumer accepts on valid && ready
//   pressed  - debounced vector has at least one active line
//   multi    - pending event captured more than one active line
//   overflow - sticky: an event was dropped while one was pending
// Optional: define BUTTON_ENCODER_REPEAT_EN for auto-repeat every
// REPEAT_CYCLES cycles while a key stays held.
module button_encoder
  import button_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_CYCLES   = 50000000,
  parameter int unsigned REPEAT_W        = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LINES-1:0] btn_n,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic              pressed,
  output logic              multi,
  output logic              overflow
);

  if (REPEAT_CYCLES < 1 || (64'd1 << REPEAT_W) <= 64'(REPEAT_CYCLES)) begin : g_bad_repeat
    $error("REPEAT_W too narrow for REPEAT_CYCLES");
  end

  logic [N_LINES-1:0] stable, stable_next;

  debounce_vec #(
    .WIDTH          (N_LINES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk_i        (clk),
    .rst_i        (rst),
    .raw_n_i      (btn_n),
    .stable_o     (stable),
    .stable_next_o(stable_next)
  );

  // FSM and event logic look at stable_next so that valid rises on the same
  // edge as the stable vector, not one cycle later.
  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RELEASED: if (stable_next != '0) state_d = PRESSED;
      PRESSED:  if (stable_next == '0) state_d = RELEASED;
    endcase
  end

  logic press_evt;
  assign press_evt = (state_q == RELEASED) && (state_d == PRESSED);

  logic rep_evt;
`ifdef BUTTON_ENCODER_REPEAT_EN
  logic [REPEAT_W-1:0] rep_cnt_q, rep_cnt_d;

  // Counter is held at 0 except while staying in PRESSED; it wraps on firing
  // so repeats land every REPEAT_CYCLES after the press event.
  always_comb begin
    rep_cnt_d = '0;
    rep_evt   = 1'b0;
    if (state_q == PRESSED && state_d == PRESSED) begin
      if (rep_cnt_q == REPEAT_W'(REPEAT_CYCLES - 1)) rep_evt = 1'b1;
      else rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rep_cnt_q <= '0;
    else     rep_cnt_q <= rep_cnt_d;
  end
`else
  always_comb rep_evt = 1'b0;
`endif

  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              multi_q, multi_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    multi_d = multi_q;
    ovf_d   = ovf_q;
    if (press_evt || rep_evt) begin
      if (!valid_q || ready) begin
        valid_d = 1'b1;
        code_d  = lowest_index(stable_next);
        multi_d = multi_hot(stable_next);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RELEASED;
      valid_q <= 1'b0;
      code_q  <= '0;
      multi_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      multi_q <= multi_d;
      ovf_q   <= ovf_d;
    end
  end

  assign code     = code_q;
  assign valid    = valid_q;
  assign multi    = multi_q;
  assign overflow = ovf_q;
  assign pressed  = |stable;

endmodule

// File: tb/tb_button_encoder.sv
module tb_button_encoder;

  localparam int D = 4;
  localparam int R = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] btn_n = 8'hFF;
  logic       ready = 1'b0;
  logic [2:0] code;
  logic       valid, pressed, multi, overflow;

  button_encoder #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3),
    .REPEAT_CYCLES  (R),
    .REPEAT_W       (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_n   (btn_n),
    .code    (code),
    .valid   (valid),
    .ready   (ready),
    .pressed (pressed),
    .multi   (multi),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Stable vector = sampled value once the last D+1 samples (seen two edges
  // late through the synchroniser) all agree. Events: rising from all-zero,
  // plus (repeat build) every R edges after the press while held.
  logic [7:0]  hist[$];
  logic [7:0]  m_stable;
  logic        m_valid, m_multi, m_ovf;
  logic [2:0]  m_code;
  int unsigned edge_n = 0;
  int unsigned press_edge = 0;
  bit          m_live = 1'b0;

  function automatic logic [2:0] low_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  always @(posedge clk) begin
    logic [7:0] s, nstab;
    bit all_eq, evt;
    edge_n++;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < D + 3; i++) hist.push_back(8'h00);
      m_stable = 8'h00;
      m_valid  = 1'b0;
      m_code   = 3'd0;
      m_multi  = 1'b0;
      m_ovf    = 1'b0;
      m_live   = 1'b1;
    end else if (m_live) begin
      s = ~btn_n;
      hist.push_back(s);
      void'(hist.pop_front());
      nstab  = m_stable;
      all_eq = 1'b1;
      for (int i = 0; i <= D; i++) if (hist[i] != hist[D]) all_eq = 1'b0;
      if (all_eq) nstab = hist[D];
      evt = 1'b0;
      if (m_stable == 8'h00 && nstab != 8'h00) begin
        evt = 1'b1;
        press_edge = edge_n;
      end
`ifdef BUTTON_ENCODER_REPEAT_EN
      else if (m_stable != 8'h00 && nstab != 8'h00 && ((edge_n - press_edge) % R) == 0)
        evt = 1'b1;
`endif
      if (evt) begin
        if (!m_valid || ready) begin
          m_valid = 1'b1;
          m_code  = low_idx(nstab);
          m_multi = $countones(nstab) > 1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
      m_stable = nstab;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("valid",    valid,    m_valid);
      chk("code",     code,     m_code);
      chk("multi",    multi,    m_multi);
      chk("pressed",  pressed,  m_stable != 8'h00);
      chk("overflow", overflow, m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int unsigned n_ev, ev_sum, hold, sel;
    logic [7:0] v;

    // Reset, then idle.
    rst = 1'b1; btn_n = 8'hFF; ready = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    chk("rst_valid", valid, 0);
    chk("rst_code", code, 0);
    chk("rst_pressed", pressed, 0);
    chk("rst_multi", multi, 0);
    chk("rst_ovf", overflow, 0);
    cycles(50);
    chk("idle_valid", valid, 0);

    // Single clean press of line 5.
    btn_n = 8'hDF;
    cycles(6);
    chk("pre_evt_valid", valid, 0);
    chk("pre_evt_pressed", pressed, 0);
    cycles(1);
    chk("evt_valid", valid, 1);
    chk("evt_code", code, 5);
    chk("evt_multi", multi, 0);
    chk("evt_pressed", pressed, 1);
    ready = 1'b1;
    cycles(1);
    chk("acc_valid", valid, 0);
    ready = 1'b0;
    btn_n = 8'hFF;
    cycles(12);
    chk("rel_valid", valid, 0);
    chk("rel_pressed", pressed, 0);

    // Short glitch on line 0.
    btn_n = 8'hFE;
    cycles(3);
    btn_n = 8'hFF;
    cycles(12);
    chk("glitch_valid", valid, 0);
    chk("glitch_pressed", pressed, 0);

    // Multi-key press, then rollover while held.
    btn_n = 8'hB6;
    cycles(7);
    chk("mk_valid", valid, 1);
    chk("mk_code", code, 0);
    chk("mk_multi", multi, 1);
    ready = 1'b1;
    cycles(1);
    ready = 1'b0;
    btn_n = 8'hB4;
    cycles(6);
    chk("roll_noevt", valid, 0);
    btn_n = 8'hFF;
    cycles(12);

    // Overflow: second press while first event still pending.
    ready = 1'b0;
    btn_n = 8'hFE; cycles(9);
    btn_n = 8'hFF; cycles(9);
    btn_n = 8'hFB; cycles(9);
    btn_n = 8'hFF; cycles(9);
    chk("ovf_valid", valid, 1);
    chk("ovf_code", code, 0);
    chk("ovf_flag", overflow, 1);
    ready = 1'b1;
    cycles(1);
    ready = 1'b0;
    chk("ovf_drain_valid", valid, 0);
    chk("ovf_sticky", overflow, 1);
    cycles(5);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("ovf_cleared", overflow, 0);
    cycles(4);

    // Held key with ready high: repeat events only in the repeat build.
    ready = 1'b1;
    btn_n = 8'hF7;
    n_ev = 0; ev_sum = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (valid) begin
        n_ev++;
        ev_sum += i;
        chk("rep_code", code, 3);
      end
    end
`ifdef BUTTON_ENCODER_REPEAT_EN
    chk("rep_count", n_ev, 3);
    chk("rep_edges", ev_sum, 6 + 22 + 38);
`else
    chk("rep_count", n_ev, 1);
    chk("rep_edges", ev_sum, 6);
`endif
    btn_n = 8'hFF;
    cycles(12);
    ready = 1'b0;

    // Randomized segments against the model.
    for (int seg = 0; seg < 250; seg++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      v = 8'hFF;
      else if (sel < 8) v = ~(8'h01 << $urandom_range(0, 7));
      else              v = 8'($urandom);
      hold = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 12);
      btn_n = v;
      for (int c = 0; c < int'(hold); c++) begin
        ready = ($urandom_range(0, 2) == 0);
        rst   = ($urandom_range(0, 199) == 0);
        @(negedge clk);
      end
      rst = 1'b0;
    end

    btn_n = 8'hFF;
    ready = 1'b1;
    cycles(20);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/button_encoder.md
Name: button_encoder

Overview:
- Input-side counterpart of the 3:8 active-low select decoder: reads 8 active-low button/key lines and returns a 3-bit code.
- Per press: synchronise, debounce as a vector, priority-encode to the 3-bit index, deliver one event over a valid/ready handshake.
- Sits between board push-buttons/keypad columns and the control FSMs. Code numbering matches the decoder's: code 0 corresponds to line 0.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised vector must hold unchanged before it is accepted (10 ms at 100 MHz); must be >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 50000000, auto-repeat interval in cycles; used only with REPEAT_EN.
- REPEAT_W, 26, repeat counter width; must satisfy 2^REPEAT_W > REPEAT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_n  in  8  raw active-low lines; asynchronous to clk; 0 = pressed.
- code  out  3  index of the lowest-numbered pressed line in the event; stable while valid.
- valid  out  1  event pending.
- ready  in  1  consumer accepts; the transfer happens on a cycle with valid && ready.
- pressed  out  1  level: debounced vector has at least one line active.
- multi  out  1  the event captured more than one active line; qualified by valid.
- overflow  out  1  sticky: an event was dropped; cleared only by rst.

Behaviour:
- Reset values: code=0, valid=0, pressed=0, multi=0, overflow=0. Synchroniser flops reset to 8'hFF (released), and so do the candidate and stable vectors. Debounce counter resets to 0. FSM resets to RELEASED.
- Synchroniser:
  - Two flops per bit.
  - Inversion to active-high happens after the second flop.
- Debounce:
  - If the synchronised vector differs from the candidate, load candidate and clear the counter.
  - Otherwise increment the counter, saturating.
  - When the counter equals DEBOUNCE_CYCLES-1 and the vectors still match, stable <= candidate on the next edge.
  - Any bounce restarts the count.
- Latency: call the edge that first samples a clean new value edge 0. The stable vector updates, and any resulting event asserts valid, after edge DEBOUNCE_CYCLES+2.
- FSM states and transitions:
  - RELEASED -> PRESSED when the stable vector becomes non-zero. This is the press event.
  - PRESSED -> RELEASED when the stable vector becomes all-zero.
  - Key changes while in PRESSED (rollover, extra keys) generate no event.
- Event generation:
  - code = lowest set index of the stable vector.
  - multi = popcount > 1.
  - Both are registered together with valid.
- Handshake:
  - valid holds, and code/multi hold stable, until valid && ready.
  - valid deasserts on the edge after acceptance unless a new event loads on that same edge, in which case valid stays high with the new code.
  - One-deep: if an event arises while valid && !ready, it is dropped, the pending event is kept, and overflow <= 1.
  - ready while valid=0 is ignored.
- pressed: follows the stable vector with the same latency; it is independent of the handshake.
- Release never generates an event.
- A press that bounces shorter than DEBOUNCE_CYCLES generates nothing.
- rst mid-debounce or with valid pending: everything returns to reset values on that edge and the pending event is lost. Lines held during reset produce a fresh event DEBOUNCE_CYCLES+2 edges after rst falls.

Optional Feature:
- Macro: BUTTON_ENCODER_REPEAT_EN.
- Defined:
  - In PRESSED, a REPEAT_W counter counts from the press event.
  - Every REPEAT_CYCLES cycles it generates another event carrying the current stable vector's code/multi.
  - The counter clears on a state change or rst.
  - Repeat events obey the one-deep/overflow rules.
- Undefined: no repeat counter is instantiated; exactly one event per press.

Decomposition:
- Shared package (display/input package), holding:
  - the state encoding: RELEASED=1'b0, PRESSED=1'b1;
  - the code width constant CODE_W=3;
  - the line count N_LINES=8.
- One sub-module, debounce_vec: synchroniser, candidate/counter, stable output, parameterised by width and DEBOUNCE_CYCLES.
- Priority encode, FSM and handshake stay in button_encoder.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3, REPEAT_CYCLES=16, REPEAT_W=5):
- Reset with btn_n=8'hFF -> all outputs 0; no event over 50 cycles.
- btn_n=8'hDF held clean from edge 0 -> valid=1, code=5, multi=0, pressed=1 after edge 6; ready=1 one cycle -> valid=0; release -> no event, pressed=0.
- btn_n glitches to 8'hFE for 3 cycles then back to 8'hFF -> no valid, pressed stays 0.
- btn_n=8'hB6 (lines 0,3,6) -> code=0, multi=1; with the key held, adding line 1 -> no new event.
- ready=0 held; press, release, press line 2 -> first event (code 0) kept, overflow=1; after ready, valid drops and overflow stays 1 until rst.
- With BUTTON_ENCODER_REPEAT_EN: hold 8'hF7, ready=1 -> events with code=3 at edge 6, 22, 38; without the macro -> only edge 6.
